// File: rtl/lock_requester_if.sv
// Command and acknowledge stream bundle between the lock requester and the manager.
interface lock_requester_if #(
    parameter int ACC_ID_BITS = 8
);
    logic                   cmd_tvalid;
    logic                   cmd_tready;
    logic [63:0]            cmd_tdata;
    logic [ACC_ID_BITS-1:0] cmd_tid;
    logic [4:0]             cmd_tdest;
    logic                   cmd_tlast;
    logic                   ack_tvalid;
    logic                   ack_tready;
    logic [63:0]            ack_tdata;

    // Requester side: drives commands, consumes acknowledges.
    modport master (
        output cmd_tvalid, cmd_tdata, cmd_tid, cmd_tdest, cmd_tlast, ack_tready,
        input  cmd_tready, ack_tvalid, ack_tdata
    );

    // Manager side: consumes commands, drives acknowledges.
    modport slave (
        input  cmd_tvalid, cmd_tdata, cmd_tid, cmd_tdest, cmd_tlast, ack_tready,
        output cmd_tready, ack_tvalid, ack_tdata
    );
endinterface

// File: rtl/lock_requester.sv
// Accelerator-side lock/unlock initiator: issues one command word per operation
// to the lock resource, waits for the grant on lock and retries after a fixed
// backoff on reject.
module lock_requester #(
    parameter int ACC_ID_BITS    = 8,
    parameter int LOCK_ID_BITS   = 8,
    parameter int BACKOFF_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [ACC_ID_BITS-1:0]  acc_id,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic                    op_unlock,
    input  logic [LOCK_ID_BITS-1:0] op_lock_id,
    output logic                    op_done,
    output logic                    held,
    output logic [LOCK_ID_BITS-1:0] held_id,
    output logic [15:0]             retries,
    output logic                    err,
    lock_requester_if.master        bus
);

    localparam logic [7:0] OPC_LOCK   = 8'h04;
    localparam logic [7:0] OPC_UNLOCK = 8'h06;
    localparam logic [7:0] ACK_OK     = 8'h01;
    localparam logic [7:0] ACK_REJECT = 8'h00;
    localparam logic [4:0] LOCK_DEST  = 5'h15;

    // The backoff counter is loaded with BACKOFF_CYCLES-1 and counts down to zero,
    // so BACKOFF occupies exactly BACKOFF_CYCLES cycles.
    localparam int               CNT_W        = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BACKOFF_LOAD = CNT_W'(BACKOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_LOCK,
        ST_WAIT_ACK,
        ST_BACKOFF,
        ST_SEND_UNLOCK
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic                    r_op_done;
    logic                    r_held;
    logic [LOCK_ID_BITS-1:0] r_held_id;
    logic [LOCK_ID_BITS-1:0] r_lock_id;
    logic [15:0]             r_retries;
    logic                    r_err;
    logic [63:0]             r_cmd_tdata;
    logic [CNT_W-1:0]        r_backoff_cnt;

    logic                    w_accept;
    logic                    w_cmd_fire;
    logic                    w_ack_fire;
    logic [7:0]              w_ack_code;
    logic                    w_ack_ok;
    logic                    w_ack_bad;
    logic                    w_unlock_bad;
    logic [7:0]              w_lock_id8;
    logic                    w_unused_ack;

    // Handshake and decode helpers.
    assign w_accept     = op_valid && op_ready;
    assign w_cmd_fire   = bus.cmd_tvalid && bus.cmd_tready;
    assign w_ack_fire   = bus.ack_tvalid && bus.ack_tready;
    assign w_ack_code   = bus.ack_tdata[7:0];
    assign w_ack_ok     = (w_ack_code == ACK_OK);
    assign w_ack_bad    = (w_ack_code != ACK_OK) && (w_ack_code != ACK_REJECT);
    assign w_unlock_bad = !r_held || (op_lock_id != r_held_id);
    assign w_lock_id8   = 8'(op_lock_id);
    assign w_unused_ack = ^bus.ack_tdata[63:8];

    // Stream and status outputs; valid/ready follow the state directly so a reset
    // drops them without waiting for a clock.
    assign op_ready       = (r_state == ST_IDLE) && !r_op_done;
    assign op_done        = r_op_done;
    assign held           = r_held;
    assign held_id        = r_held_id;
    assign retries        = r_retries;
    assign err            = r_err;
    assign bus.cmd_tvalid = (r_state == ST_SEND_LOCK) || (r_state == ST_SEND_UNLOCK);
    assign bus.cmd_tdata  = r_cmd_tdata;
    assign bus.cmd_tid    = acc_id;
    assign bus.cmd_tdest  = LOCK_DEST;
    assign bus.cmd_tlast  = 1'b1;
    assign bus.ack_tready = (r_state == ST_WAIT_ACK);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state decode.
    // NOTE: the default assignment first keeps this block latch-free on every path.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (op_unlock)    w_next_state = ST_SEND_UNLOCK;
                    else if (!r_held) w_next_state = ST_SEND_LOCK;
                end
            end
            ST_SEND_LOCK:   if (w_cmd_fire) w_next_state = ST_WAIT_ACK;
            ST_WAIT_ACK:    if (w_ack_fire) w_next_state = w_ack_ok ? ST_IDLE : ST_BACKOFF;
            ST_BACKOFF:     if (r_backoff_cnt == '0) w_next_state = ST_SEND_LOCK;
            ST_SEND_UNLOCK: if (w_cmd_fire) w_next_state = ST_IDLE;
            default:        w_next_state = ST_IDLE;
        endcase
    end

    // Command word, ownership, retry/backoff counters, error flag and completion pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_op_done     <= 1'b0;
            r_held        <= 1'b0;
            r_held_id     <= '0;
            r_lock_id     <= '0;
            r_retries     <= '0;
            r_err         <= 1'b0;
            r_cmd_tdata   <= '0;
            r_backoff_cnt <= '0;
        end else begin
            r_op_done <= 1'b0;

            if ((r_state == ST_IDLE) && w_accept) begin
                if (op_unlock) begin
                    // The unlock goes out even when it looks wrong; only the flag records it.
                    r_cmd_tdata <= {48'h0, w_lock_id8, OPC_UNLOCK};
                    if (w_unlock_bad) r_err <= 1'b1;
                end else if (r_held) begin
                    // No nesting: complete immediately with an error, nothing is sent.
                    r_err     <= 1'b1;
                    r_op_done <= 1'b1;
                end else begin
                    r_lock_id   <= op_lock_id;
                    r_retries   <= '0;
                    r_cmd_tdata <= {48'h0, w_lock_id8, OPC_LOCK};
                end
            end

            if ((r_state == ST_WAIT_ACK) && w_ack_fire) begin
                if (w_ack_ok) begin
                    r_held    <= 1'b1;
                    r_held_id <= r_lock_id;
                    r_op_done <= 1'b1;
                end else begin
                    if (r_retries != 16'hFFFF) r_retries <= r_retries + 16'd1;
                    if (w_ack_bad)             r_err     <= 1'b1;
                    r_backoff_cnt <= BACKOFF_LOAD;
                end
            end

            if ((r_state == ST_BACKOFF) && (r_backoff_cnt != '0))
                r_backoff_cnt <= r_backoff_cnt - CNT_W'(1);

            if ((r_state == ST_SEND_UNLOCK) && w_cmd_fire) begin
                r_held    <= 1'b0;
                r_op_done <= 1'b1;
            end
        end
    end

endmodule
